// File: rtl/calc_host_ctrl.sv
// Host-side job controller for a small calculator processor.
// Loads operands, runs the core, snoops the result write, reads back.
module calc_host_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h00000000,
  parameter int unsigned RUN_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] opcode,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        timeout,
  output logic        cpu_reset,
  output logic        host_sel,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_addr
);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_OP,
    CLR_RES, RUN, READ, DONE
  } state_t;

  localparam logic [31:0] RES_ADDR = BASE_ADDR + 32'hC;
  localparam logic [15:0] LAST = 16'(RUN_CYCLES - 1);

  state_t      st, nxt;
  logic [31:0] a_q, b_q, op_q;
  logic [15:0] cnt;
  logic        to_q;
  logic        hit;
  logic        expire;

  assign hit = cpu_memwrite && (cpu_addr == RES_ADDR);
  assign expire = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:    if (start) nxt = WR_A;
      WR_A:    nxt = WR_B;
      WR_B:    nxt = WR_OP;
      WR_OP:   nxt = CLR_RES;
      CLR_RES: nxt = RUN;
      RUN:     if (hit || expire) nxt = READ;
      READ:    nxt = DONE;
      DONE:    nxt = IDLE;
    endcase
    if (abort && st != IDLE) nxt = IDLE;
  end

  // Snoop has priority: timeout latch reflects only the final RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt     <= '0;
      to_q    <= 1'b0;
      result  <= '0;
      timeout <= 1'b0;
    end else begin
      if (st == IDLE && start) begin
        a_q  <= op_a;
        b_q  <= op_b;
        op_q <= opcode;
      end
      if (st == CLR_RES)  cnt <= '0;
      else if (st == RUN) cnt <= cnt + 16'd1;
      if (st == RUN) to_q <= !hit;
      if (st == READ && !abort) begin
        result  <= mem_rdata;
        timeout <= to_q;
      end
    end
  end

  always_comb begin
    busy      = (st != IDLE);
    done      = (st == DONE);
    cpu_reset = (st != RUN);
    host_sel  = (st != RUN);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (st)
      WR_A: begin
        mem_we    = 1'b1;
        mem_addr  = BASE_ADDR;
        mem_wdata = a_q;
      end
      WR_B: begin
        mem_we    = 1'b1;
        mem_addr  = BASE_ADDR + 32'h4;
        mem_wdata = b_q;
      end
      WR_OP: begin
        mem_we    = 1'b1;
        mem_addr  = BASE_ADDR + 32'h8;
        mem_wdata = op_q;
      end
      CLR_RES: begin
        mem_we    = 1'b1;
        mem_addr  = RES_ADDR;
      end
      READ:    mem_addr = RES_ADDR;
      default: ;
    endcase
  end

endmodule

// File: doc/calc_host_ctrl.md
CALC_HOST_CTRL -- requirements
Module: calc_host_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00000000, byte address of the operand block (A at +0x0, B at +0x4, operator at +0x8, result at +0xC).
REQ-002 SHALL have parameter RUN_CYCLES, default 100, maximum processor run cycles per job (range 1..65535).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  job request; sampled only in IDLE.
REQ-006 op_a, op_b, opcode  in  32 each  operand 1, operand 2, operator code (1 add, 3 mul, 4 div, ...).
REQ-007 abort  in  1  cancels the current job.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when result is valid.
REQ-010 result  out  32  last captured result; held until the next DONE.
REQ-011 timeout  out  1  set when the last job ended by count, not by the result write; held like result.
REQ-012 cpu_reset  out  1  active-high reset driven to the processor.
REQ-013 host_sel  out  1  1 = this block owns the data-memory port (external mux).
REQ-014 mem_we, mem_addr[31:0], mem_wdata[31:0]  out  data-memory write port.
REQ-015 mem_rdata  in  32  combinational data-memory read data for mem_addr.
REQ-016 cpu_memwrite, cpu_addr[31:0]  in  1/32  snoop of the processor data-memory write strobe and address.

Function
REQ-017 States SHALL be IDLE, WR_A, WR_B, WR_OP, CLR_RES, RUN, READ, DONE.
REQ-018 IDLE: start=1 latches op_a/op_b/opcode and moves to WR_A next edge; start outside IDLE is ignored.
REQ-019 WR_A, WR_B, WR_OP, CLR_RES: one cycle each, in order; mem_we=1, mem_addr=BASE_ADDR+0x0/0x4/0x8/0xC, mem_wdata=latched A/B/opcode/0.
REQ-020 cpu_reset=1 and host_sel=1 in IDLE, WR_*, CLR_RES, READ, DONE; both 0 only in RUN.
REQ-021 mem_we SHALL be 0 outside WR_A..CLR_RES; mem_addr/mem_wdata are don't-care when host_sel=0.
REQ-022 RUN: 16-bit counter cleared on entry and incremented every RUN cycle.
REQ-023 RUN exits to READ on the first cycle cpu_memwrite=1 with cpu_addr==BASE_ADDR+0xC (timeout latch cleared), else when the counter reaches RUN_CYCLES-1 (timeout latch set); the snoop wins if both occur in the same cycle.
REQ-024 The exit edge SHALL be the edge ending the qualifying cycle, so the processor write commits on that edge.
REQ-025 READ: one cycle, mem_addr=BASE_ADDR+0xC; result and timeout update from mem_rdata and the latch on the exit edge.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 Latency: start sampled at edge k -> RUN starts cycle k+5; no-snoop job gives done in cycle k+RUN_CYCLES+6.
REQ-028 abort=1 in any state but IDLE -> IDLE next edge with cpu_reset=1, host_sel=1, mem_we=0, no done; result/timeout unchanged.
REQ-029 All address arithmetic 32-bit unsigned, wrap-around allowed.

Reset
REQ-030 reset low -> immediately IDLE, busy=0, done=0, result=0, timeout=0, cpu_reset=1, host_sel=1, mem_we=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-031 reset asserted mid-RUN SHALL drop the job; the processor is held in reset from assertion onward.

Verification
REQ-032 A=10, B=5, op=1; model writes 15 to 0x0C at RUN cycle 20 -> memory 0x0..0xC = 10,5,1,0 before RUN; result=15, timeout=0, done one cycle.
REQ-033 A=4, B=6, op=3; model writes 24 at RUN cycle 40 -> result=24 (0x18), timeout=0.
REQ-034 A=50, B=0, op=4; model never writes 0x0C -> done exactly RUN_CYCLES+6 cycles after start; result=0, timeout=1.
REQ-035 start pulsed in WR_B and RUN -> ignored; one done per accepted job; latched operands unchanged.
REQ-036 abort in WR_OP, then reset low in RUN of a new job -> no done either time; IDLE, cpu_reset=1, result keeps the prior value until reset, then 0.
